// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage pipeline: forwarding, load-use stall, branch flush, data-memory wait sequencing.
// Optional performance counters are enabled with `define HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic [1:0] ResultSrcE,
    input  logic [1:0] ResultSrcM,
    input  logic       MemWriteM,
    input  logic       PCSrcE,
    input  logic       dmem_ready,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       dmem_req,
    output logic       mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
`endif
);

    localparam logic [0:0]  ST_IDLE     = 1'b0;
    localparam logic [0:0]  ST_WAIT     = 1'b1;
    localparam logic [1:0]  RES_LOAD    = 2'b01;
    localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

    if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535) || (CNT_WIDTH < 1)) begin : g_param_check
        $error("pipeline_hazard_ctrl: TIMEOUT_CYCLES must be 1..65535 and CNT_WIDTH >= 1");
    end

    logic        memop_m;
    logic        mem_stall;
    logic        lw_stall;
    logic [0:0]  state_q, state_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    // M-stage ALU result wins over W result: it is the younger write.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m, input logic [4:0] rd_m,
                                           input logic wr_w, input logic [4:0] rd_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))      return 2'b10;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) return 2'b01;
        else                                             return 2'b00;
    endfunction

    assign memop_m   = MemWriteM | (ResultSrcM == RES_LOAD);
    assign dmem_req  = memop_m;
    assign mem_stall = memop_m & ~dmem_ready;
    assign lw_stall  = (ResultSrcE == RES_LOAD) & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

    assign ForwardAE = fwd_sel(Rs1E, RegWriteM, RdM, RegWriteW, RdW);
    assign ForwardBE = fwd_sel(Rs2E, RegWriteM, RdM, RegWriteW, RdW);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            // Frozen pipeline: a pending branch or load-use waits in place until memory completes.
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall | PCSrcE;
            FlushD = PCSrcE;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                wait_cnt_d = 16'd0;
                if (mem_stall) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 16'd1;
                end
            end
            ST_WAIT: begin
                if (dmem_ready || !memop_m) begin
                    state_d    = ST_IDLE;
                    wait_cnt_d = 16'd0;
                end else if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                wait_cnt_d = 16'd0;
            end
        endcase
        mem_timeout_d = mem_timeout_q | ((state_d == ST_WAIT) && (wait_cnt_d >= TIMEOUT_LIM));
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= ST_IDLE;
            wait_cnt_q    <= 16'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(StallF);
            flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(FlushE);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule
